// File: rtl/mm2axi4_burst_pkg.sv
// Shared definitions for the mm2axi4_burst bridge: AXI constants, FSM states
// and the AxSIZE helper.
package mm2axi4_burst_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_DONE
  } state_t;

  // AxSIZE encoding for a data bus of the given width in bits.
  function automatic logic [2:0] axi_size(input int unsigned datalen);
    logic [2:0] s;
    s = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd8 << i) == datalen) s = i[2:0];
    end
    return s;
  endfunction

endpackage

// File: rtl/mm2axi4_burst_if.sv
// AXI4 master-side bus bundle between mm2axi4_burst and the memory controller.
interface mm2axi4_burst_if #(
  parameter int AXI4_IDLEN   = 4,
  parameter int AXI4_ADDRLEN = 27,
  parameter int AXI4_DATALEN = 32
) ();

  logic [AXI4_IDLEN-1:0]     m_axi_awid;
  logic [AXI4_ADDRLEN:0]     m_axi_awaddr;
  logic [7:0]                m_axi_awlen;
  logic [2:0]                m_axi_awsize;
  logic [1:0]                m_axi_awburst;
  logic                      m_axi_awvalid;
  logic                      m_axi_awready;
  logic [AXI4_DATALEN-1:0]   m_axi_wdata;
  logic [AXI4_DATALEN/8-1:0] m_axi_wstrb;
  logic                      m_axi_wlast;
  logic                      m_axi_wvalid;
  logic                      m_axi_wready;
  logic [1:0]                m_axi_bresp;
  logic                      m_axi_bvalid;
  logic                      m_axi_bready;
  logic [AXI4_IDLEN-1:0]     m_axi_arid;
  logic [AXI4_ADDRLEN:0]     m_axi_araddr;
  logic [7:0]                m_axi_arlen;
  logic [2:0]                m_axi_arsize;
  logic [1:0]                m_axi_arburst;
  logic                      m_axi_arvalid;
  logic                      m_axi_arready;
  logic [AXI4_DATALEN-1:0]   m_axi_rdata;
  logic [1:0]                m_axi_rresp;
  logic                      m_axi_rlast;
  logic                      m_axi_rvalid;
  logic                      m_axi_rready;

  modport master (
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
           m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
           m_axi_bready, m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
           m_axi_arburst, m_axi_arvalid, m_axi_rready,
    input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
           m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
  );

  modport slave (
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
           m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
           m_axi_bready, m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
           m_axi_arburst, m_axi_arvalid, m_axi_rready,
    output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
           m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
  );

endinterface

// File: rtl/mm2axi4_burst.sv
// Simple memory-mapped master to AXI4 INCR burst bridge with per-cycle beat
// streaming, 4 KB / length rejection and a sticky error flag.
module mm2axi4_burst
  import mm2axi4_burst_pkg::*;
#(
  parameter int AXI4_IDLEN   = 4,
  parameter int AXI4_ADDRLEN = 27,
  parameter int AXI4_DATALEN = 32,
  parameter int MAX_LEN      = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             a,
  input  logic [AXI4_DATALEN-1:0] d,
  input  logic                    we,
  input  logic                    rd,
  input  logic                    burst_en,
  input  logic [7:0]              burst_length,
  output logic [AXI4_DATALEN-1:0] spo,
  output logic                    beat,
  output logic                    ready,
  output logic                    irq,
  mm2axi4_burst_if.master         m_axi
);

  localparam int unsigned NBYTES = AXI4_DATALEN / 8;
  localparam logic [2:0]  SIZE   = axi_size(AXI4_DATALEN);

  state_t                state;
  logic [7:0]            cnt;
  logic [7:0]            len_q;
  logic [AXI4_ADDRLEN:0] addr_q;
  logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                  r_beat_q;

  logic [31:0] a_al;
  logic [7:0]  req_len;
  logic [15:0] span_end;
  logic        reject;
  logic        unused_addr;

  assign a_al        = a & ~(32'(NBYTES - 1));
  assign req_len     = burst_en ? burst_length : 8'd0;
  assign span_end    = 16'(a_al[11:0]) + ((16'(req_len) + 16'd1) << SIZE);
  assign reject      = (span_end > 16'd4096) || (32'(req_len) > 32'(MAX_LEN));
  assign unused_addr = ^a_al[31:AXI4_ADDRLEN+1];

  assign m_axi.m_axi_awid    = '0;
  assign m_axi.m_axi_awaddr  = addr_q;
  assign m_axi.m_axi_awlen   = len_q;
  assign m_axi.m_axi_awsize  = SIZE;
  assign m_axi.m_axi_awburst = AXI_BURST_INCR;
  assign m_axi.m_axi_awvalid = awvalid_q;
  assign m_axi.m_axi_wdata   = d;
  assign m_axi.m_axi_wstrb   = '1;
  assign m_axi.m_axi_wlast   = wvalid_q && (cnt == len_q);
  assign m_axi.m_axi_wvalid  = wvalid_q;
  assign m_axi.m_axi_bready  = bready_q;
  assign m_axi.m_axi_arid    = '0;
  assign m_axi.m_axi_araddr  = addr_q;
  assign m_axi.m_axi_arlen   = len_q;
  assign m_axi.m_axi_arsize  = SIZE;
  assign m_axi.m_axi_arburst = AXI_BURST_INCR;
  assign m_axi.m_axi_arvalid = arvalid_q;
  assign m_axi.m_axi_rready  = rready_q;

  // Write beats strobe in the handshake cycle; read beats one cycle later with spo.
  assign beat = (wvalid_q && m_axi.m_axi_wready) || r_beat_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      r_beat_q  <= 1'b0;
      ready     <= 1'b0;
      irq       <= 1'b0;
      spo       <= '0;
    end else begin
      r_beat_q <= 1'b0;
      ready    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (we || rd) begin
            cnt    <= '0;
            len_q  <= req_len;
            addr_q <= a_al[AXI4_ADDRLEN:0];
            irq    <= reject;
            if (reject) begin
              ready <= 1'b1;
              state <= ST_DONE;
            end else if (we) begin
              awvalid_q <= 1'b1;
              state     <= ST_AW;
            end else begin
              arvalid_q <= 1'b1;
              state     <= ST_AR;
            end
          end
        end
        ST_AW: begin
          if (m_axi.m_axi_awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            state     <= ST_W;
          end
        end
        ST_W: begin
          if (m_axi.m_axi_wready) begin
            cnt <= cnt + 8'd1;
            if (cnt == len_q) begin
              wvalid_q <= 1'b0;
              bready_q <= 1'b1;
              state    <= ST_B;
            end
          end
        end
        ST_B: begin
          if (m_axi.m_axi_bvalid) begin
            bready_q <= 1'b0;
            if (m_axi.m_axi_bresp != AXI_RESP_OKAY) irq <= 1'b1;
            ready <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_AR: begin
          if (m_axi.m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= ST_R;
          end
        end
        ST_R: begin
          // rready drops after the final beat; the next cycle presents spo, then DONE.
          if (rready_q) begin
            if (m_axi.m_axi_rvalid) begin
              spo      <= m_axi.m_axi_rdata;
              r_beat_q <= 1'b1;
              cnt      <= cnt + 8'd1;
              if (m_axi.m_axi_rresp != AXI_RESP_OKAY) irq <= 1'b1;
              if (m_axi.m_axi_rlast || (cnt == len_q)) begin
                rready_q <= 1'b0;
                if (m_axi.m_axi_rlast != (cnt == len_q)) irq <= 1'b1;
              end
            end
          end else begin
            ready <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mm2axi4_burst.md
Name: mm2axi4_burst

Overview:
Parametrised successor of the single-beat mm2axi4 bridge. Converts the SoC's simple memory-mapped master interface into AXI4 INCR bursts of up to MAX_LEN+1 beats. It sits between serialboot/cache_cpu (burst_en/burst_length are finally honoured) and the MIG AXI slave. Data width is generic, beats are streamed per cycle, and bus errors are reported.

Parameters:
AXI4_IDLEN, 4, width of awid/arid (driven 0)
AXI4_ADDRLEN, 27, AXI address width; MSB index, bus is [AXI4_ADDRLEN:0]
AXI4_DATALEN, 32, data width in bits; power of two, 32..256
MAX_LEN, 255, largest accepted burst_length (AXI len = beats-1)

Ports:
clk  in  1  single clock domain (ui_clk)
rst_n  in  1  synchronous, active-low reset
a  in  32  byte address; low log2(DATALEN/8) bits ignored
d  in  DATALEN  write data for current beat
we  in  1  write request, level, held until ready
rd  in  1  read request, level, held until ready
burst_en  in  1  1: use burst_length; 0: single beat
burst_length  in  8  beats-1
spo  out  DATALEN  read data, valid when beat=1 during read
beat  out  1  one-cycle strobe per accepted/delivered beat
ready  out  1  one-cycle completion strobe
irq  out  1  sticky error flag
m_axi_awid/arid  out  IDLEN  constant 0
m_axi_awaddr/araddr  out  ADDRLEN+1  aligned start address
m_axi_awlen/arlen  out  8  beats-1
m_axi_awsize/arsize  out  3  log2(DATALEN/8)
m_axi_awburst/arburst  out  2  2'b01 INCR
m_axi_awvalid/arvalid  out  1  address valid
m_axi_awready/arready  in  1  address accept
m_axi_wdata  out  DATALEN  = d
m_axi_wstrb  out  DATALEN/8  all ones
m_axi_wlast  out  1  final write beat
m_axi_wvalid  out  1  write data valid
m_axi_wready  in  1  write data accept
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  response valid
m_axi_bready  out  1  response accept
m_axi_rdata  in  DATALEN  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  last read beat
m_axi_rvalid  in  1  read data valid
m_axi_rready  out  1  read data accept

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; all valid/ready outputs, beat, ready, irq = 0; spo = 0; beat counter = 0. Mid-transaction reset abandons the AXI transfer; the slave's aresetn is driven from the same reset at top level.
- States: IDLE, AW, W, B, AR, R, DONE.
- IDLE: if we → AW, else if rd → AR; we wins if both. Latch len = burst_en ? burst_length : 0 and the aligned address.
- Reject: len > MAX_LEN, or the burst crosses a 4 KB boundary (addr[11:0] + (len+1)*bytes > 4096). Either sets irq, issues no AXI traffic, and goes to DONE.
- AW: awvalid=1 until awready, then W. AR: arvalid=1 until arready, then R.
- W: wvalid=1, wdata=d. Each wvalid&wready pulses beat in the same cycle and increments the counter; the client presents the next d on the following cycle. wlast=1 when counter==len. Last handshake → B.
- B: bready=1; on bvalid → DONE; bresp!=0 sets irq.
- R: rready=1. Each rvalid registers spo<=rdata and pulses beat next cycle (spo valid with beat). rresp!=0 sets irq. rlast, or counter==len (rlast trusted; mismatch sets irq) → DONE after the last beat is presented.
- DONE: ready=1 for one cycle → IDLE. Client must drop we/rd in the ready cycle; a request still high one cycle later is a new transaction.
- Minimum latency, single write with slave always ready: AW 1, W 1, B 1, DONE → ready 4 cycles after request. Single read: ready 4 cycles after request, spo valid 1 cycle before ready.
- irq clears only when a new request is accepted in IDLE (or on reset).
- len=0 is a single beat, with wlast=1 on the first beat.

Decomposition:
- Shared package: AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00, the state encoding, and the SIZE function log2(DATALEN/8).
- No sub-module; the FSM plus an 8-bit beat counter stay in one file.

Test Plan:
- Single write, a=0x100, d=0xDEADBEEF, burst_en=0, slave always ready → awaddr=0x100, awlen=0, one wlast beat, ready at cycle 4, irq=0.
- Read burst, burst_len=7 from 0x2000, slave inserts rvalid gaps → 8 beat strobes, spo equals each rdata in order, ready after last beat.
- Write burst len=15 with wready toggling every cycle → exactly 16 beat strobes, wlast only on the 16th, d advances only after beat.
- 4 KB crossing: a=0xFF0, len=7, DATALEN=32 → no awvalid, ready strobe, irq=1; next valid request clears irq.
- bresp=2'b10 on a single write → ready pulses, irq=1; assert rst_n=0 during an R burst → all outputs 0 next cycle, state IDLE.
- we and rd asserted together → write path taken, no arvalid.
